// File: rtl/instruction_fetch_if.sv
// Fetch-unit bus bundle: instruction-memory request side plus the issue handshake to execute.
// The master modport is the fetch unit; the slave modport is memory/execute (or a bench).
interface instruction_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        jump_flag;
  logic [31:0] ALU_result;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, pc_out, pc_plus4,
    input  imem_ready, imem_rdata, inst_ready, jump_flag, ALU_result
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, pc_out, pc_plus4,
    output imem_ready, imem_rdata, inst_ready, jump_flag, ALU_result
  );
endinterface

// File: rtl/instruction_fetch.sv
// RV32I instruction fetch: owns the PC, fetches one word at a time and hands it to execute,
// redirecting on resolved jumps and halting on a misaligned target.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  instruction_fetch_if.master bus,
  output logic                fault,
  output logic [31:0]         fault_addr,
  output logic [31:0]         inst_count
);

  typedef enum logic [1:0] {StFetch, StIssue, StHalt} state_e;

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        fault_q, fault_d;
  logic [31:0] fault_addr_q, fault_addr_d;
  logic [31:0] count_q, count_d;

  logic        accept;
  logic        consume;
  logic [31:0] target;

  // Request is registered so it stays low through reset and never depends on inputs.
  assign accept  = (state_q == StFetch) && req_q && bus.imem_ready;
  assign consume = (state_q == StIssue) && bus.inst_ready;
  assign target  = bus.ALU_result & 32'hFFFF_FFFE;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch: if (accept) state_d = StIssue;
      StIssue: begin
        if (consume) begin
          state_d = (bus.jump_flag && target[1]) ? StHalt : StFetch;
        end
      end
      StHalt:  state_d = StHalt;
      default: state_d = StFetch;
    endcase
  end

  always_comb begin
    bus.imem_req   = req_q;
    bus.imem_addr  = pc_q;
    bus.inst_valid = (state_q == StIssue);
    bus.inst       = inst_q;
    bus.pc_out     = pc_q;
    bus.pc_plus4   = pc_q + 32'd4;
    fault          = fault_q;
    fault_addr     = fault_addr_q;
    inst_count     = count_q;
  end

  always_comb begin
    req_d        = (state_d == StFetch);
    pc_d         = pc_q;
    inst_d       = inst_q;
    fault_d      = fault_q;
    fault_addr_d = fault_addr_q;
    count_d      = count_q;
    if (accept) begin
      inst_d = bus.imem_rdata;
    end
    if (consume) begin
      count_d = count_q + 32'd1;
      if (bus.jump_flag) begin
        if (target[1]) begin
          fault_d      = 1'b1;
          fault_addr_d = target;
        end else begin
          pc_d = target;
        end
      end else begin
        pc_d = pc_q + 32'd4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q        <= 1'b0;
      pc_q         <= RESET_PC;
      inst_q       <= 32'h0;
      fault_q      <= 1'b0;
      fault_addr_q <= 32'h0;
      count_q      <= 32'h0;
    end else begin
      req_q        <= req_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
      count_q      <= count_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: fetched words are queued when memory answers and
// checked against what execute sees; a small PC/count model tracks redirects and faults.
module tb_instruction_fetch;

  logic        clk;
  logic        rst;
  logic        fault;
  logic [31:0] fault_addr;
  logic [31:0] inst_count;

  instruction_fetch_if bus ();

  instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .fault      (fault),
    .fault_addr (fault_addr),
    .inst_count (inst_count)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  exp_t        exp_q[$];
  int          n_vec;
  int          n_err;
  logic [31:0] model_pc;
  logic [31:0] model_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    bus.imem_ready = 1'b1;
    bus.inst_ready = 1'b0;
    bus.jump_flag  = 1'b0;
    @(negedge clk);
    check_val("rst_req0", 32'(bus.imem_req), 32'd0);
    @(negedge clk);
    check_val("rst_req1", 32'(bus.imem_req), 32'd0);
    rst            = 1'b0;
    bus.imem_ready = 1'b0;
    exp_q.delete();
    model_pc  = 32'h0;
    model_cnt = 32'h0;
  endtask

  task automatic reset_checks();
    check_val("rst_valid", 32'(bus.inst_valid), 32'd0);
    check_val("rst_inst", bus.inst, 32'h0);
    check_val("rst_pc", bus.pc_out, 32'h0);
    check_val("rst_fault", 32'(fault), 32'd0);
    check_val("rst_faddr", fault_addr, 32'h0);
    check_val("rst_count", inst_count, 32'h0);
  endtask

  task automatic wait_req(output bit ok);
    int t = 0;
    while (!bus.imem_req && t < 16) begin
      @(negedge clk);
      t++;
    end
    ok = bus.imem_req;
    check_val("req_seen", 32'(bus.imem_req), 32'd1);
  endtask

  task automatic fetch(input int waits, input logic [31:0] word);
    bit ok;
    wait_req(ok);
    if (!ok) return;
    check_val("fetch_addr", bus.imem_addr, model_pc);
    for (int i = 0; i < waits; i++) begin
      bus.imem_ready = 1'b0;
      bus.imem_rdata = $urandom;
      @(negedge clk);
      check_val("req_held", 32'(bus.imem_req), 32'd1);
      check_val("addr_held", bus.imem_addr, model_pc);
    end
    bus.imem_rdata = word;
    bus.imem_ready = 1'b1;
    exp_q.push_back('{pc: model_pc, word: word});
    @(negedge clk);
    bus.imem_ready = 1'b0;
    bus.imem_rdata = $urandom;
    check_val("req_drop", 32'(bus.imem_req), 32'd0);
  endtask

  task automatic issue(input int stall, input logic jump, input logic [31:0] alu);
    int          t = 0;
    exp_t        e;
    logic [31:0] tgt;
    while (!bus.inst_valid && t < 16) begin
      @(negedge clk);
      t++;
    end
    check_val("valid_seen", 32'(bus.inst_valid), 32'd1);
    if (!bus.inst_valid) return;
    check_val("sb_depth", 32'(exp_q.size()), 32'd1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    check_val("inst", bus.inst, e.word);
    check_val("pc_out", bus.pc_out, e.pc);
    check_val("pc_plus4", bus.pc_plus4, e.pc + 32'd4);
    for (int i = 0; i < stall; i++) begin
      bus.inst_ready = 1'b0;
      bus.jump_flag  = 1'b1;
      bus.ALU_result = $urandom;
      @(negedge clk);
      check_val("stall_valid", 32'(bus.inst_valid), 32'd1);
      check_val("stall_inst", bus.inst, e.word);
      check_val("stall_pc", bus.pc_out, e.pc);
    end
    bus.inst_ready = 1'b1;
    bus.jump_flag  = jump;
    bus.ALU_result = alu;
    @(negedge clk);
    bus.inst_ready = 1'b0;
    bus.jump_flag  = 1'b0;
    model_cnt++;
    tgt = {alu[31:1], 1'b0};
    if (jump && tgt[1]) begin
      check_val("fault", 32'(fault), 32'd1);
      check_val("fault_addr", fault_addr, tgt);
      check_val("halt_pc", bus.pc_out, model_pc);
      check_val("halt_req", 32'(bus.imem_req), 32'd0);
    end else begin
      model_pc = jump ? tgt : model_pc + 32'd4;
      check_val("next_req", 32'(bus.imem_req), 32'd1);
      check_val("next_addr", bus.imem_addr, model_pc);
    end
    check_val("count", inst_count, model_cnt);
    check_val("valid_drop", 32'(bus.inst_valid), 32'd0);
  endtask

  initial begin
    bit ok;
    n_vec          = 0;
    n_err          = 0;
    bus.imem_ready = 1'b0;
    bus.imem_rdata = 32'h0;
    bus.inst_ready = 1'b0;
    bus.jump_flag  = 1'b0;
    bus.ALU_result = 32'h0;
    do_reset();
    reset_checks();

    // Straight-line fetch, both sides always ready.
    for (int i = 0; i < 4; i++) begin
      fetch(0, 32'h0000_0013 + (i << 7));
      issue(0, 1'b0, 32'h0);
    end

    fetch(3, 32'hDEAD_BEEF);
    issue(0, 1'b0, 32'h0);

    fetch(0, 32'h0040_006F);
    issue(5, 1'b1, 32'h0000_0101);

    // Wrap-around from the top of the address space.
    fetch(0, 32'h1111_1111);
    issue(0, 1'b1, 32'hFFFF_FFFC);
    fetch(1, 32'h2222_2222);
    issue(0, 1'b0, 32'h0);
    fetch(0, 32'h3333_3333);
    issue(2, 1'b0, 32'h0);

    // Misaligned target halts until reset.
    fetch(0, 32'h0000_0067);
    issue(0, 1'b1, 32'h0000_0206);
    for (int i = 0; i < 6; i++) begin
      bus.inst_ready = 1'b1;
      bus.imem_ready = 1'b1;
      bus.jump_flag  = 1'b1;
      bus.ALU_result = 32'h0000_0040;
      @(negedge clk);
      check_val("halt_req_hold", 32'(bus.imem_req), 32'd0);
      check_val("halt_valid", 32'(bus.inst_valid), 32'd0);
      check_val("halt_fault", 32'(fault), 32'd1);
    end
    bus.inst_ready = 1'b0;
    bus.jump_flag  = 1'b0;
    do_reset();
    reset_checks();

    // Reset mid-fetch, then a stale ready while the request is still low.
    fetch(0, 32'hA5A5_0001);
    issue(0, 1'b0, 32'h0);
    wait_req(ok);
    repeat (2) @(negedge clk);
    do_reset();
    reset_checks();
    bus.imem_ready = 1'b1;
    bus.imem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    bus.imem_ready = 1'b0;
    check_val("stale_valid", 32'(bus.inst_valid), 32'd0);
    check_val("stale_inst", bus.inst, 32'h0);
    check_val("stale_req", 32'(bus.imem_req), 32'd1);
    fetch(0, 32'hA5A5_0002);
    issue(0, 1'b0, 32'h0);

    // Reset mid-issue discards the pending instruction.
    fetch(0, 32'hA5A5_0003);
    do_reset();
    reset_checks();
    fetch(0, 32'hA5A5_0004);
    issue(1, 1'b0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
